// File: rtl/lsu_response_assembler.sv
// LSU response assembler: tracks in-flight memory instructions, scatters
// out-of-order response blocks into per-thread words, retires in order.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   alloc_*              instruction allocation from the coalesce splitter
//   alloc_id_o           com_id (tail pointer) given to the allocating instr
//   sub_*                block sub-request registration (always accepted)
//   mem_rsp_*            memory response block (always accepted)
//   rc_to_eu_ready_i     result collector ready
//   eu_to_rc_*           completed instruction result, allocation order
module lsu_response_assembler #(
    parameter int unsigned RegWidth               = 32,
    parameter int unsigned WarpWidth              = 4,
    parameter int unsigned RegIdxWidth            = 8,
    parameter type         iid_t                  = logic,
    parameter int unsigned BlockIdxBits           = 4,
    parameter int unsigned OutstandingReqIdxWidth = 3,
    localparam int unsigned BlockWidth     = 1 << BlockIdxBits,
    localparam int unsigned ThreadIdxWidth =
        (WarpWidth > 1) ? $clog2(WarpWidth) : 1,
    localparam int unsigned ReqIdWidth     =
        OutstandingReqIdxWidth + ThreadIdxWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,

    input  logic                                alloc_valid_i,
    output logic                                alloc_ready_o,
    input  iid_t                                alloc_tag_i,
    input  logic [RegIdxWidth-1:0]              alloc_dst_i,
    input  logic                                alloc_we_i,
    input  logic [WarpWidth-1:0]                alloc_act_mask_i,
    output logic [OutstandingReqIdxWidth-1:0]   alloc_id_o,

    input  logic                                sub_valid_i,
    input  logic [ReqIdWidth-1:0]               sub_req_id_i,
    input  logic [WarpWidth-1:0]                sub_mask_i,
    input  logic [WarpWidth*BlockIdxBits-1:0]   sub_offsets_i,

    input  logic                                mem_rsp_valid_i,
    input  logic [ReqIdWidth-1:0]               mem_rsp_id_i,
    input  logic [BlockWidth*8-1:0]             mem_rsp_data_i,

    input  logic                                rc_to_eu_ready_i,
    output logic                                eu_to_rc_valid_o,
    output iid_t                                eu_to_rc_tag_o,
    output logic [RegIdxWidth-1:0]              eu_to_rc_dst_o,
    output logic [RegWidth*WarpWidth-1:0]       eu_to_rc_data_o
);

    localparam int unsigned NumEntries = 1 << OutstandingReqIdxWidth;
    localparam int unsigned NumIds     = 1 << ReqIdWidth;
    localparam int unsigned RegBytes   = RegWidth / 8;

    typedef logic [OutstandingReqIdxWidth-1:0] com_t;
    typedef logic [WarpWidth-1:0][RegWidth-1:0] wdata_t;
    typedef logic [WarpWidth-1:0][BlockIdxBits-1:0] offs_t;

    // Entry table
    logic [NumEntries-1:0]   valid_q, valid_d;
    logic [NumEntries-1:0]   we_q, we_d;
    iid_t                    tag_q [NumEntries];
    iid_t                    tag_d [NumEntries];
    logic [RegIdxWidth-1:0]  dst_q [NumEntries];
    logic [RegIdxWidth-1:0]  dst_d [NumEntries];
    logic [WarpWidth-1:0]    act_q [NumEntries];
    logic [WarpWidth-1:0]    act_d [NumEntries];
    logic [WarpWidth-1:0]    pend_q [NumEntries];
    logic [WarpWidth-1:0]    pend_d [NumEntries];
    wdata_t                  data_q [NumEntries];
    wdata_t                  data_d [NumEntries];

    // Sub-request table, indexed by the full req_id
    logic [WarpWidth-1:0]    sub_mask_q [NumIds];
    logic [WarpWidth-1:0]    sub_mask_d [NumIds];
    offs_t                   sub_off_q [NumIds];
    offs_t                   sub_off_d [NumIds];

    com_t                    head_q, head_d;
    com_t                    tail_q, tail_d;

    // Response decode
    com_t                    rsp_com;
    logic [WarpWidth-1:0]    rsp_mask;
    offs_t                   rsp_off;
    wdata_t                  rsp_word;
    logic                    rsp_hit;
    logic                    rsp_off_bad;

    logic                    alloc_fire;
    logic                    pop;

    assign rsp_com  = mem_rsp_id_i[ReqIdWidth-1:ThreadIdxWidth];
    assign rsp_mask = sub_mask_q[mem_rsp_id_i];
    assign rsp_off  = sub_off_q[mem_rsp_id_i];
    assign rsp_hit  = mem_rsp_valid_i && valid_q[rsp_com];

    // Each thread's word is the block shifted down to its byte offset.
    always_comb begin
        rsp_word    = '0;
        rsp_off_bad = 1'b0;
        for (int i = 0; i < WarpWidth; i++) begin
            rsp_word[i] = RegWidth'(mem_rsp_data_i >> {rsp_off[i], 3'b000});
            if (rsp_mask[i] &&
                (32'(rsp_off[i]) + RegBytes > BlockWidth)) begin
                rsp_off_bad = 1'b1;
            end
        end
    end

    assign alloc_ready_o = !valid_q[tail_q];
    assign alloc_id_o    = tail_q;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

    assign eu_to_rc_valid_o = valid_q[head_q] && (pend_q[head_q] == '0);
    assign eu_to_rc_tag_o   = tag_q[head_q];
    assign eu_to_rc_dst_o   = dst_q[head_q];
    assign pop              = eu_to_rc_valid_o && rc_to_eu_ready_i;

    always_comb begin
        eu_to_rc_data_o = '0;
        for (int i = 0; i < WarpWidth; i++) begin
            if (act_q[head_q][i] && !we_q[head_q]) begin
                eu_to_rc_data_o[i*RegWidth +: RegWidth] = data_q[head_q][i];
            end
        end
    end

    // Alloc, response and pop touch different entries in the same cycle:
    // alloc needs an invalid tail, pop a valid head, responses a valid entry.
    always_comb begin
        valid_d    = valid_q;
        we_d       = we_q;
        tag_d      = tag_q;
        dst_d      = dst_q;
        act_d      = act_q;
        pend_d     = pend_q;
        data_d     = data_q;
        sub_mask_d = sub_mask_q;
        sub_off_d  = sub_off_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (sub_valid_i) begin
            sub_mask_d[sub_req_id_i] = sub_mask_i;
            sub_off_d[sub_req_id_i]  = sub_offsets_i;
        end

        if (rsp_hit) begin
            pend_d[rsp_com] = pend_q[rsp_com] & ~rsp_mask;
            if (!we_q[rsp_com]) begin
                for (int i = 0; i < WarpWidth; i++) begin
                    if (rsp_mask[i]) begin
                        data_d[rsp_com][i] = rsp_word[i];
                    end
                end
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + com_t'(1);
        end

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            we_d[tail_q]    = alloc_we_i;
            tag_d[tail_q]   = alloc_tag_i;
            dst_d[tail_q]   = alloc_dst_i;
            act_d[tail_q]   = alloc_act_mask_i;
            pend_d[tail_q]  = alloc_act_mask_i;
            data_d[tail_q]  = '0;
            tail_d          = tail_q + com_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            we_q       <= '0;
            tag_q      <= '{default: '0};
            dst_q      <= '{default: '0};
            act_q      <= '{default: '0};
            pend_q     <= '{default: '0};
            data_q     <= '{default: '0};
            sub_mask_q <= '{default: '0};
            sub_off_q  <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            we_q       <= we_d;
            tag_q      <= tag_d;
            dst_q      <= dst_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            sub_mask_q <= sub_mask_d;
            sub_off_q  <= sub_off_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    a_rsp_valid_entry: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem_rsp_valid_i |-> valid_q[rsp_com]
    );

    a_rsp_offset_fits: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        rsp_hit |-> !rsp_off_bad
    );

endmodule

// File: tb/tb_lsu_response_assembler.sv
// Bench for lsu_response_assembler: scoreboard of allocated instructions
// plus a small scatter model, checked when results are popped.
module tb_lsu_response_assembler;

    localparam int RW  = 32;
    localparam int WW  = 4;
    localparam int NE  = 8;
    localparam int NID = 32;

    typedef logic [7:0] tag_t;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           alloc_valid_i;
    logic           alloc_ready_o;
    tag_t           alloc_tag_i;
    logic [7:0]     alloc_dst_i;
    logic           alloc_we_i;
    logic [3:0]     alloc_act_mask_i;
    logic [2:0]     alloc_id_o;
    logic           sub_valid_i;
    logic [4:0]     sub_req_id_i;
    logic [3:0]     sub_mask_i;
    logic [15:0]    sub_offsets_i;
    logic           mem_rsp_valid_i;
    logic [4:0]     mem_rsp_id_i;
    logic [127:0]   mem_rsp_data_i;
    logic           rc_to_eu_ready_i;
    logic           eu_to_rc_valid_o;
    tag_t           eu_to_rc_tag_o;
    logic [7:0]     eu_to_rc_dst_o;
    logic [127:0]   eu_to_rc_data_o;

    lsu_response_assembler #(
        .RegWidth(32),
        .WarpWidth(4),
        .RegIdxWidth(8),
        .iid_t(logic [7:0]),
        .BlockIdxBits(4),
        .OutstandingReqIdxWidth(3)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .alloc_valid_i(alloc_valid_i),
        .alloc_ready_o(alloc_ready_o),
        .alloc_tag_i(alloc_tag_i),
        .alloc_dst_i(alloc_dst_i),
        .alloc_we_i(alloc_we_i),
        .alloc_act_mask_i(alloc_act_mask_i),
        .alloc_id_o(alloc_id_o),
        .sub_valid_i(sub_valid_i),
        .sub_req_id_i(sub_req_id_i),
        .sub_mask_i(sub_mask_i),
        .sub_offsets_i(sub_offsets_i),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_id_i(mem_rsp_id_i),
        .mem_rsp_data_i(mem_rsp_data_i),
        .rc_to_eu_ready_i(rc_to_eu_ready_i),
        .eu_to_rc_valid_o(eu_to_rc_valid_o),
        .eu_to_rc_tag_o(eu_to_rc_tag_o),
        .eu_to_rc_dst_o(eu_to_rc_dst_o),
        .eu_to_rc_data_o(eu_to_rc_data_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Model state
    typedef struct {
        tag_t       tag;
        logic [7:0] dst;
        int         com;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [3:0]    msub_mask [NID];
    logic [15:0]   msub_off [NID];
    logic [RW-1:0] mdata [NE][WW];
    logic          mwe [NE];
    logic [3:0]    mact [NE];
    int            mtail;

    function automatic logic [RW-1:0] word_at(input logic [127:0] blk,
                                              input int off);
        logic [RW-1:0] w;
        for (int b = 0; b < RW/8; b++) w[8*b +: 8] = blk[8*(off+b) +: 8];
        return w;
    endfunction

    function automatic logic [127:0] exp_data(input int com);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < WW; i++)
            if (mact[com][i] && !mwe[com]) d[RW*i +: RW] = mdata[com][i];
        return d;
    endfunction

    function automatic logic [4:0] id_of(input int com, input int thr);
        return {3'(com), 2'(thr)};
    endfunction

    function automatic logic [15:0] mk_off(input int o0, input int o1,
                                           input int o2, input int o3);
        return {4'(o3), 4'(o2), 4'(o1), 4'(o0)};
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_alloc(input tag_t t, input logic [7:0] d,
                            input logic we, input logic [3:0] m,
                            output int com);
        check("alloc_ready", alloc_ready_o, 1);
        check("alloc_id", alloc_id_o, mtail);
        alloc_valid_i    = 1'b1;
        alloc_tag_i      = t;
        alloc_dst_i      = d;
        alloc_we_i       = we;
        alloc_act_mask_i = m;
        com       = mtail;
        mact[com] = m;
        mwe[com]  = we;
        for (int i = 0; i < WW; i++) mdata[com][i] = '0;
        sb.push_back('{t, d, com});
        mtail = (mtail + 1) % NE;
        tick();
        alloc_valid_i = 1'b0;
    endtask

    task automatic do_sub(input logic [4:0] id, input logic [3:0] m,
                          input logic [15:0] offs);
        msub_mask[id] = m;
        msub_off[id]  = offs;
        sub_valid_i   = 1'b1;
        sub_req_id_i  = id;
        sub_mask_i    = m;
        sub_offsets_i = offs;
        tick();
        sub_valid_i = 1'b0;
    endtask

    task automatic do_rsp(input logic [4:0] id, input logic [127:0] blk);
        int com;
        com = int'(id >> 2);
        for (int i = 0; i < WW; i++)
            if (msub_mask[id][i] && !mwe[com])
                mdata[com][i] = word_at(blk, int'(msub_off[id][4*i +: 4]));
        mem_rsp_valid_i = 1'b1;
        mem_rsp_id_i    = id;
        mem_rsp_data_i  = blk;
        tick();
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni          = 1'b0;
        alloc_valid_i   = 1'b0;
        sub_valid_i     = 1'b0;
        mem_rsp_valid_i = 1'b0;
        sb.delete();
        mtail = 0;
        tick();
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_valid", eu_to_rc_valid_o, 0);
        check("rst_ready", alloc_ready_o, 1);
        check("rst_id", alloc_id_o, 0);
        check("rst_tag", eu_to_rc_tag_o, 0);
        check("rst_dst", eu_to_rc_dst_o, 0);
        check("rst_data", eu_to_rc_data_o, 0);
    endtask

    // Scoreboard: every popped result against the oldest allocation.
    always @(negedge clk_i) begin
        if (rst_ni && eu_to_rc_valid_o && rc_to_eu_ready_i) begin
            if (sb.size() == 0) begin
                check("spurious_pop", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("pop_tag", eu_to_rc_tag_o, mon_e.tag);
                check("pop_dst", eu_to_rc_dst_o, mon_e.dst);
                check("pop_data", eu_to_rc_data_o, exp_data(mon_e.com));
            end
        end
    end

    int c, ca, cb;
    logic [127:0] exp6;

    initial begin
        rst_ni           = 1'b0;
        alloc_valid_i    = 1'b0;
        alloc_tag_i      = '0;
        alloc_dst_i      = '0;
        alloc_we_i       = 1'b0;
        alloc_act_mask_i = '0;
        sub_valid_i      = 1'b0;
        sub_req_id_i     = '0;
        sub_mask_i       = '0;
        sub_offsets_i    = '0;
        mem_rsp_valid_i  = 1'b0;
        mem_rsp_id_i     = '0;
        mem_rsp_data_i   = '0;
        rc_to_eu_ready_i = 1'b1;
        mtail            = 0;
        do_reset();

        // Single block, aligned offsets
        do_alloc(8'h05, 8'h03, 1'b0, 4'b1111, c);
        do_sub(id_of(c, 0), 4'b1111, mk_off(0, 4, 8, 12));
        @(negedge clk_i);
        check("t1_wait", eu_to_rc_valid_o, 0);
        do_rsp(id_of(c, 0), 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        @(negedge clk_i);
        check("t1_valid", eu_to_rc_valid_o, 1);
        check("t1_tag", eu_to_rc_tag_o, 8'h05);
        check("t1_dst", eu_to_rc_dst_o, 8'h03);
        check("t1_data", eu_to_rc_data_o,
              128'h0F0E0D0C_0B0A0908_07060504_03020100);

        // Two sub-requests, responses reversed, unaligned offsets
        do_alloc(8'h11, 8'h07, 1'b0, 4'b1111, c);
        do_sub(id_of(c, 0), 4'b0011,
               mk_off($urandom_range(12, 0), $urandom_range(12, 0), 0, 0));
        do_sub(id_of(c, 2), 4'b1100,
               mk_off(0, 0, $urandom_range(12, 0), $urandom_range(12, 0)));
        do_rsp(id_of(c, 2), rand_blk());
        @(negedge clk_i);
        check("t2_first", eu_to_rc_valid_o, 0);
        do_rsp(id_of(c, 0), rand_blk());
        @(negedge clk_i);
        check("t2_second", eu_to_rc_valid_o, 1);

        // In-order retirement
        do_alloc(8'h0A, 8'h01, 1'b0, 4'b1111, ca);
        do_alloc(8'h0B, 8'h02, 1'b0, 4'b1111, cb);
        do_sub(id_of(ca, 0), 4'b1111, mk_off(1, 3, 5, 7));
        do_sub(id_of(cb, 0), 4'b1111, mk_off(12, 8, 2, 0));
        do_rsp(id_of(cb, 0), rand_blk());
        repeat (3) begin
            @(negedge clk_i);
            check("t3_hold", eu_to_rc_valid_o, 0);
            tick();
        end
        do_rsp(id_of(ca, 0), rand_blk());
        @(negedge clk_i);
        check("t3_a_valid", eu_to_rc_valid_o, 1);
        check("t3_a_tag", eu_to_rc_tag_o, 8'h0A);
        tick();
        @(negedge clk_i);
        check("t3_b_valid", eu_to_rc_valid_o, 1);
        check("t3_b_tag", eu_to_rc_tag_o, 8'h0B);
        tick();

        // Full table and tail wrap
        do_reset();
        for (int i = 0; i < 8; i++)
            do_alloc(8'(8'h20 + i), 8'(i), 1'b0, 4'b0001, c);
        check("t4_full", alloc_ready_o, 0);
        do_sub(id_of(0, 0), 4'b0001, mk_off(0, 0, 0, 0));
        do_rsp(id_of(0, 0), rand_blk());
        check("t4_head_valid", eu_to_rc_valid_o, 1);
        check("t4_no_bypass", alloc_ready_o, 0);
        tick();
        check("t4_ready_again", alloc_ready_o, 1);
        check("t4_wrap_id", alloc_id_o, 0);
        do_alloc(8'h30, 8'h09, 1'b0, 4'b0001, c);
        for (int k = 1; k < 8; k++) begin
            do_sub(id_of(k, 0), 4'b0001,
                   mk_off($urandom_range(12, 0), 0, 0, 0));
            do_rsp(id_of(k, 0), rand_blk());
        end
        do_sub(id_of(0, 0), 4'b0001, mk_off(6, 0, 0, 0));
        do_rsp(id_of(0, 0), rand_blk());

        // Partial, empty and store masks
        do_alloc(8'h50, 8'h0C, 1'b0, 4'b0101, c);
        do_sub(id_of(c, 0), 4'b0101, mk_off(3, 0, 9, 0));
        do_rsp(id_of(c, 0), rand_blk());
        @(negedge clk_i);
        check("t5_valid", eu_to_rc_valid_o, 1);
        check("t5_thr1", eu_to_rc_data_o[63:32], 0);
        check("t5_thr3", eu_to_rc_data_o[127:96], 0);
        do_alloc(8'h51, 8'h0D, 1'b0, 4'b0000, c);
        @(negedge clk_i);
        check("t5_empty_valid", eu_to_rc_valid_o, 1);
        do_alloc(8'h52, 8'h0E, 1'b1, 4'b1111, c);
        do_sub(id_of(c, 0), 4'b1111, mk_off(0, 4, 8, 12));
        do_rsp(id_of(c, 0), rand_blk() | 128'h1);
        @(negedge clk_i);
        check("t5_store_valid", eu_to_rc_valid_o, 1);
        check("t5_store_data", eu_to_rc_data_o, 0);
        tick();

        // Backpressure
        rc_to_eu_ready_i = 1'b0;
        do_alloc(8'h60, 8'h0F, 1'b0, 4'b1111, c);
        do_sub(id_of(c, 0), 4'b1111, mk_off(2, 10, 5, 11));
        do_rsp(id_of(c, 0), rand_blk());
        exp6 = exp_data(c);
        repeat (5) begin
            @(negedge clk_i);
            check("t6_hold_valid", eu_to_rc_valid_o, 1);
            check("t6_hold_tag", eu_to_rc_tag_o, 8'h60);
            check("t6_hold_data", eu_to_rc_data_o, exp6);
            tick();
        end
        rc_to_eu_ready_i = 1'b1;
        @(negedge clk_i);
        tick();

        // Reset with entries in flight
        for (int i = 0; i < 3; i++)
            do_alloc(8'(8'h70 + i), 8'(i), 1'b0, 4'b1111, c);
        do_sub(id_of(c, 0), 4'b1111, mk_off(0, 0, 0, 0));
        do_reset();
        do_alloc(8'h7F, 8'h01, 1'b0, 4'b0000, c);

        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        check("drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
